// File: rtl/switch_debounce_pkg.sv
// Shared constants and helpers for the front-panel switch debouncer.
package switch_debounce_pkg;

  localparam int unsigned SwitchWidth           = 5;
  localparam logic [4:0]  SwitchIdle            = 5'b11111;
  localparam int unsigned DebounceCyclesDefault = 270000;

  // Switches are active-low, so "at most one switch on" means at most one 0 bit.
  function automatic logic at_most_one_zero(input logic [31:0] v);
    int unsigned zeros;
    zeros = 0;
    for (int i = 0; i < 32; i++) begin
      if (!v[i]) zeros = zeros + 1;
    end
    return zeros <= 1;
  endfunction

endpackage

// File: rtl/switch_debounce_sync_2ff.sv
// Two-flop synchronizer for asynchronous pin inputs, with configurable width and reset value.
module sync_2ff #(
  parameter int unsigned      Width      = 1,
  parameter logic [Width-1:0] ResetValue = '0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  logic [Width-1:0] sync1_q, sync2_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= ResetValue;
      sync2_q <= ResetValue;
    end else begin
      sync1_q <= d_i;
      sync2_q <= sync1_q;
    end
  end

  assign q_o = sync2_q;

endmodule

// File: rtl/switch_debounce.sv
// Synchronizes and debounces active-low mode switches into a clean vector.
// Define SWITCH_ONEHOT_FILTER_EN to reject stable patterns with more than one switch on.
module switch_debounce
  import switch_debounce_pkg::*;
#(
  parameter int unsigned WIDTH           = SwitchWidth,
  parameter int unsigned DEBOUNCE_CYCLES = DebounceCyclesDefault
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] switch_raw,
  output logic [WIDTH-1:0] switch_out,
  output logic             switch_changed,
  output logic             settled
);

  localparam int unsigned  CntW   = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync2;
  logic [WIDTH-1:0] cand_q, cand_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             changed_q, changed_d;
  logic             settled_q, settled_d;
  logic             accept;

  sync_2ff #(
    .Width      (WIDTH),
    .ResetValue ({WIDTH{1'b1}})
  ) u_sync (
    .clk_i  (clock),
    .rst_ni (reset_n),
    .d_i    (switch_raw),
    .q_o    (sync2)
  );

`ifdef SWITCH_ONEHOT_FILTER_EN
  logic [31:0] cand_padded;
  always_comb begin
    cand_padded              = '1;
    cand_padded[WIDTH-1:0]   = cand_q;
    accept                   = at_most_one_zero(cand_padded);
  end
`else
  assign accept = 1'b1;
`endif

  always_comb begin
    cand_d    = cand_q;
    cnt_d     = cnt_q;
    out_d     = out_q;
    changed_d = 1'b0;
    settled_d = settled_q;
    if (sync2 != cand_q) begin
      // Any bit change restarts the whole stability window.
      cand_d = sync2;
      cnt_d  = '0;
    end else if (cnt_q != CntMax) begin
      cnt_d = cnt_q + CntW'(1);
    end else begin
      settled_d = 1'b1;
      if ((cand_q != out_q) && accept) begin
        out_d     = cand_q;
        changed_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cand_q    <= '1;
      cnt_q     <= '0;
      out_q     <= '1;
      changed_q <= 1'b0;
      settled_q <= 1'b0;
    end else begin
      cand_q    <= cand_d;
      cnt_q     <= cnt_d;
      out_q     <= out_d;
      changed_q <= changed_d;
      settled_q <= settled_d;
    end
  end

  assign switch_out     = out_q;
  assign switch_changed = changed_q;
  assign settled        = settled_q;

endmodule

// File: tb/tb_switch_debounce.sv
// Scoreboard bench for switch_debounce with DEBOUNCE_CYCLES=4; pulses are checked by a monitor.
module tb_switch_debounce;
  import switch_debounce_pkg::*;

  localparam int unsigned W   = 5;
  localparam int unsigned D   = 4;
  localparam int          Lat = D + 3;

  logic         clock = 1'b0;
  logic         reset_n = 1'b0;
  logic [W-1:0] switch_raw = '1;
  logic [W-1:0] switch_out;
  logic         switch_changed;
  logic         settled;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    logic [W-1:0] val;
    int           at;
  } exp_t;
  exp_t exp_q[$];

  switch_debounce #(
    .WIDTH           (W),
    .DEBOUNCE_CYCLES (D)
  ) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .switch_raw     (switch_raw),
    .switch_out     (switch_out),
    .switch_changed (switch_changed),
    .settled        (settled)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Drive a new raw pattern after edge t=cyc; a pulse, if expected, lands after edge t+Lat.
  task automatic drive(input logic [W-1:0] v, input bit expect_pulse);
    switch_raw = v;
    if (expect_pulse) exp_q.push_back('{val: v, at: cyc + Lat});
  endtask

  // Monitor: every pulse must match the head of the expected queue in value and cycle.
  initial begin
    logic prev;
    exp_t e;
    prev = 1'b0;
    forever begin
      @(posedge clock);
      #1;
      if (switch_changed === 1'b1) begin
        check("pulse_expected", exp_q.size() > 0, 1);
        check("pulse_not_back_to_back", prev, 0);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("pulse_value", switch_out, e.val);
          check("pulse_cycle", cyc, e.at);
        end
      end
      prev = switch_changed;
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] filt_exp;
    int           r;

    // Reset / idle
    step(2);
    check("reset_out", switch_out, SwitchIdle);
    check("reset_changed", switch_changed, 0);
    check("reset_settled", settled, 0);
    reset_n = 1'b1;
    // Release between edges: counter runs 1,2,3 then settled sets on the fourth edge.
    for (int k = 1; k <= D + 1; k++) begin
      @(negedge clock);
      check("settled_rise", settled, (k >= D) ? 1 : 0);
    end
    check("idle_out", switch_out, SwitchIdle);

    // Clean change
    drive(5'b11110, 1'b1);
    step(Lat + 2);
    check("clean_out", switch_out, 5'b11110);

    // Bounce, then final hold
    for (int i = 0; i < 10; i++) begin
      switch_raw = (i % 2 == 0) ? 5'b11101 : 5'b11111;
      step(2);
      check("bounce_hold", switch_out, 5'b11110);
    end
    drive(5'b11101, 1'b1);
    step(Lat + 2);
    check("bounce_out", switch_out, 5'b11101);

    // Revert: back to 11110, then a short excursion to 11111
    drive(5'b11110, 1'b1);
    step(Lat + 2);
    check("revert_base", switch_out, 5'b11110);
    switch_raw = 5'b11111;
    step(3);
    switch_raw = 5'b11110;
    step(Lat + 3);
    check("revert_out", switch_out, 5'b11110);

    // Multi-switch pattern
`ifdef SWITCH_ONEHOT_FILTER_EN
    filt_exp = 5'b11110;
    drive(5'b11100, 1'b0);
`else
    filt_exp = 5'b11100;
    drive(5'b11100, 1'b1);
`endif
    step(Lat + 3);
    check("filter_out", switch_out, filt_exp);
    check("filter_settled", settled, 1);

    // Reset mid-window
    drive(5'b10111, 1'b0);
    step(2);
    reset_n = 1'b0;
    #1;
    check("midreset_out", switch_out, SwitchIdle);
    check("midreset_changed", switch_changed, 0);
    check("midreset_settled", settled, 0);
    step(2);
    reset_n = 1'b1;
    r = cyc;
    exp_q.push_back('{val: 5'b10111, at: r + Lat});
    step(Lat - 1);
    check("midreset_not_yet", switch_out, SwitchIdle);
    step(3);
    check("midreset_out_after", switch_out, 5'b10111);
    check("midreset_settled_after", settled, 1);

    check("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
